// File: rtl/shift_reg_ctrl.sv
// Command sequencer for a 4-bit universal shift register: accepts one command
// over valid/ready, drives mode/data/serial-in for N cycles, then reports Q.
module shift_reg_ctrl #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_data,
  input  logic             cmd_si,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [3:0]       q_in,
  output logic [1:0]       m_sel,
  output logic [3:0]       d_out,
  output logic             si_out,
  output logic             busy,
  output logic             done,
  output logic [3:0]       result
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SETTLE
  } state_t;

  localparam logic [1:0]     OP_HOLD = 2'b00;
  localparam logic [1:0]     OP_LOAD = 2'b01;
  localparam logic [CNT_W:0] ONE     = {{CNT_W{1'b0}}, 1'b1};
  localparam logic [CNT_W:0] FULL    = {1'b1, {CNT_W{1'b0}}};

  state_t         state;
  logic [CNT_W:0] cnt;
  logic [CNT_W:0] eff_cnt;

  // A zero count means a full 2^CNT_W operations; a load only ever needs one.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    eff_cnt = {1'b0, cmd_count};
    if (cmd_count == '0) eff_cnt = FULL;
    if (cmd_op == OP_LOAD) eff_cnt = ONE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      m_sel     <= OP_HOLD;
      d_out     <= 4'h0;
      si_out    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 4'h0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            m_sel     <= cmd_op;
            d_out     <= cmd_data;
            si_out    <= cmd_si;
            cnt       <= eff_cnt;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        RUN: begin
          // The register still sees the op on this edge; hold takes over after it.
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            m_sel <= OP_HOLD;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          result    <= q_in;
          done      <= 1'b1;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
Command sequencer for the team's 4-bit universal shift register (modes: 00 hold, 01 parallel load, 10 shift right with serial-in to MSB, 11 rotate left). It accepts one command at a time over a valid/ready handshake and drives the register's mode, data and serial-in inputs for the commanded number of cycles. When the command finishes, it captures the register output and pulses done. It sits between a front-end command source (switch decoder or CPU-side logic) and the register, on the same clock.

Parameters:
CNT_W, 3, width of cmd_count; a count of 0 means 2^CNT_W operations.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command.
cmd_op  input  2  00 hold/wait, 01 load, 10 shift right, 11 rotate left.
cmd_data  input  4  parallel load value.
cmd_si  input  1  serial-in bit used for shift right.
cmd_count  input  CNT_W  number of operation cycles; 0 means 2^CNT_W.
q_in  input  4  register output Q.
m_sel  output  2  mode select to the register.
d_out  output  4  data to the register D input.
si_out  output  1  serial-in to the register.
busy  output  1  command in progress.
done  output  1  one-cycle pulse; result is valid this cycle.
result  output  4  Q value captured at command completion.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; cmd_ready=0, m_sel=00, d_out=0000, si_out=0, busy=0, done=0, result=0000; internal counter=0. Applies immediately, including mid-command; the register then simply holds.
- First rising edge after reset release: cmd_ready<=1.
- All outputs are registered.
- States: IDLE, RUN, SETTLE.
- IDLE: m_sel=00. A command is accepted on an edge where cmd_valid=1 and cmd_ready=1. At that edge:
  - m_sel<=cmd_op, d_out<=cmd_data, si_out<=cmd_si.
  - cnt<=effective count (cmd_count, or 2^CNT_W if 0; forced to 1 when cmd_op=01). cnt is CNT_W+1 bits.
  - cmd_ready<=0, busy<=1, next state RUN.
  - cmd_valid while cmd_ready=0 is ignored; no queuing.
- RUN: m_sel holds the op, so the register performs it on every edge in RUN.
  - Each edge: cnt<=cnt-1.
  - On the edge where cnt==1: m_sel<=00, next state SETTLE.
  - This gives exactly N register operations for count N.
- SETTLE: q_in now reflects the final value. Next edge: result<=q_in, done<=1, busy<=0, cmd_ready<=1, next state IDLE.
- done is high for exactly one cycle and deasserts on the following edge.
- Latency: accept at edge e0; register operations on e1..eN; result/done at eN+1. Earliest next accept is eN+2 (cmd_ready high after eN+1). Throughput: one command per N+2 cycles.
- d_out and si_out hold their last values until the next accept.
- hold op (00): pure N-cycle timed wait; result = unchanged Q.
- A done pulse coinciding with a new cmd_valid: the command is not accepted on the done edge, only on a later edge while cmd_ready=1.
- No arithmetic overflow: cnt never decrements below 1 in RUN.

Test Plan:
- Reset mid-RUN (rotate, count 5, reset at cycle 2) -> all outputs immediately at reset values; cmd_ready=1 one edge after release; register holds.
- Load cmd_data=1010, cmd_count=6 -> m_sel=01 for exactly 1 cycle; done at accept+2 with result=1010; busy high 2 cycles.
- After loading 0000: shift right, cmd_si=1, count 3 -> Q sequence 1000, 1100, 1110; result=1110; m_sel=10 for exactly 3 cycles.
- After loading 1001: rotate left, count 2 -> Q 0011, 0110; result=0110.
- Rotate left, count 0 (CNT_W=3), starting from 0110 -> 8 rotations; result=0110; done at accept+9.
- Back-to-back with cmd_valid held high (load 0101, then hold count 4) -> second accept exactly 1 cycle after the first done; result 0101 both times; no command lost or duplicated.
